control_sequencer: RTL and testbench
====================================

CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 The block SHALL have port clk, input, 1 bit: single clock; all state changes occur on the rising edge.
REQ-002 The block SHALL have port clr, input, 1 bit: asynchronous, active-low reset.
REQ-003 The block SHALL have port ir, input, 32 bits: instruction register contents, with the opcode in ir[31:27].
REQ-004 The block SHALL have port con_ff, input, 1 bit: branch-condition flip-flop output.
REQ-005 The block SHALL have port stop, input, 1 bit: halt request, sampled only at instruction boundaries.
REQ-006 The block SHALL have ports PCout, Zlowout, MDRout and Cout, each output, 1 bit: bus-drive strobes.
REQ-007 The block SHALL have ports MARIn, PCIn, MDRIn, IRIn, YIn, ZIn and CONIn, each output, 1 bit: register-load strobes.
REQ-008 The block SHALL have ports IncPC, read, add and subtract, each output, 1 bit: ALU/memory controls.
REQ-009 The block SHALL have ports Gra, Grb, Grc, RIn and Rout, each output, 1 bit: register-file select and enable strobes.
REQ-010 The block SHALL have port run, output, 1 bit: high while the sequencer is not halted.
REQ-011 The block SHALL have port illegal_op, output, 1 bit: one-cycle pulse flagging an unknown opcode.

Function
REQ-012 The block SHALL be a Moore machine, with all outputs decoded from the state register only, except PCIn in state BR6 (REQ-019).
REQ-013 The states SHALL be IDLE, T0, T1, T2, T3, T4, T5, BR6 and HALT; every state SHALL last exactly one clock.
REQ-014 Fetch SHALL proceed as follows: IDLE -> T0 unconditionally; T0 = PCout, MARIn, IncPC, ZIn; T1 = Zlowout, PCIn, read, MDRIn; T2 = MDRout, IRIn.
REQ-015 Decode SHALL use ir[31:27] in T3; opcodes are add=00011, sub=00100, addi=01100, jr=10100, br=10011, nop=11010, halt=11011.
REQ-016 add/sub SHALL sequence: T3 = Grb, Rout, YIn; T4 = Grc, Rout, add (or subtract), ZIn; T5 = Zlowout, Gra, RIn; then end of instruction.
REQ-017 addi SHALL sequence: T3 = Grb, Rout, YIn; T4 = Cout, add, ZIn; T5 = Zlowout, Gra, RIn; then end of instruction.
REQ-018 jr SHALL sequence: T3 = Gra, Rout, PCIn; then end of instruction (4-cycle instruction).
REQ-019 br SHALL sequence: T3 = Gra, Rout, CONIn; T4 = PCout, YIn; T5 = Cout, add, ZIn; BR6 = Zlowout, with PCIn = con_ff sampled in BR6; then end of instruction.
REQ-020 nop SHALL perform T3 with no strobes asserted, then end of instruction.
REQ-021 halt SHALL perform T3 with no strobes asserted, then go to HALT.
REQ-022 An unknown opcode SHALL behave as nop and assert illegal_op for the T3 cycle only.
REQ-023 At end of instruction, the next state SHALL be HALT if stop=1, otherwise T0.
REQ-024 stop SHALL have no effect during T0-T2 or mid-execute.
REQ-025 HALT SHALL be absorbing: all strobes 0, run=0, exited only by reset.
REQ-026 At most one of add/subtract SHALL be high in any cycle; PCIn and MARIn SHALL never both be high.
REQ-027 run SHALL be 1 in every state except HALT.

Reset
REQ-028 clr=0 SHALL immediately force state IDLE, all strobes 0, illegal_op=0 and run=1, regardless of the current state, including mid-instruction.
REQ-029 After clr rises, the first rising edge SHALL move IDLE -> T0; a deassertion coincident with a clock edge SHALL take effect on the following edge.

Verification
REQ-030 Test: release reset with ir=add (00011) -> IDLE, T0, T1, T2, T3, T4, T5, T0 with the strobes of REQ-014/016 exactly, add=1 only in T4.
REQ-031 Test: jr (10100) -> T3 asserts Gra, Rout, PCIn; next state T0; instruction length 4 clocks.
REQ-032 Test: br with con_ff=1, then br with con_ff=0 -> BR6 PCIn = 1 and 0 respectively; Zlowout = 1 in both.
REQ-033 Test: halt opcode (11011) -> HALT after T3, run=0, all strobes 0 for 10+ clocks; clr=0 then returns to IDLE with run=1.
REQ-034 Test: opcode 11111 -> illegal_op=1 for the T3 cycle only; next state T0.
REQ-035 Test: clr=0 asserted asynchronously mid-T4 of sub -> outputs 0 before the next edge; stop=1 raised during T1 of add -> HALT entered only after T5.

Source files
------------

// File: rtl/control_sequencer.sv
// Hardwired control sequencer: fetch T0-T2, decode in T3, execute T4..BR6.
// Strobes are decoded from the state register; T3 also decodes the opcode.
module control_sequencer (
    input  logic        clk,
    input  logic        clr,
    input  logic [31:0] ir,
    input  logic        con_ff,
    input  logic        stop,
    output logic        PCout,
    output logic        Zlowout,
    output logic        MDRout,
    output logic        Cout,
    output logic        MARIn,
    output logic        PCIn,
    output logic        MDRIn,
    output logic        IRIn,
    output logic        YIn,
    output logic        ZIn,
    output logic        CONIn,
    output logic        IncPC,
    output logic        read,
    output logic        add,
    output logic        subtract,
    output logic        Gra,
    output logic        Grb,
    output logic        Grc,
    output logic        RIn,
    output logic        Rout,
    output logic        run,
    output logic        illegal_op
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_T0,
        S_T1,
        S_T2,
        S_T3,
        S_T4,
        S_T5,
        S_BR6,
        S_HALT
    } state_t;

    typedef enum logic [2:0] {
        OP_ADD,
        OP_SUB,
        OP_ADDI,
        OP_JR,
        OP_BR,
        OP_NOP,
        OP_HALT,
        OP_ILL
    } op_t;

    localparam logic [4:0] OPC_ADD  = 5'b00011;
    localparam logic [4:0] OPC_SUB  = 5'b00100;
    localparam logic [4:0] OPC_ADDI = 5'b01100;
    localparam logic [4:0] OPC_JR   = 5'b10100;
    localparam logic [4:0] OPC_BR   = 5'b10011;
    localparam logic [4:0] OPC_NOP  = 5'b11010;
    localparam logic [4:0] OPC_HALT = 5'b11011;

    state_t state_q, state_d;
    op_t    op_q, op_d;
    op_t    op_dec;
    state_t eoi_state;

    logic [4:0] opcode;
    logic       unused_ir;

    assign opcode    = ir[31:27];
    assign unused_ir = ^ir[26:0];

    always_comb begin
        op_dec = OP_ILL;
        unique case (opcode)
            OPC_ADD:  op_dec = OP_ADD;
            OPC_SUB:  op_dec = OP_SUB;
            OPC_ADDI: op_dec = OP_ADDI;
            OPC_JR:   op_dec = OP_JR;
            OPC_BR:   op_dec = OP_BR;
            OPC_NOP:  op_dec = OP_NOP;
            OPC_HALT: op_dec = OP_HALT;
            default:  op_dec = OP_ILL;
        endcase
    end

    // stop is only looked at here, so it is ignored mid-instruction
    assign eoi_state = stop ? S_HALT : S_T0;

    // The opcode class is captured leaving T3 so T4..BR6 need no ir
    assign op_d = (state_q == S_T3) ? op_dec : op_q;

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q <= S_IDLE;
            op_q    <= OP_NOP;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        PCout      = 1'b0;
        Zlowout    = 1'b0;
        MDRout     = 1'b0;
        Cout       = 1'b0;
        MARIn      = 1'b0;
        PCIn       = 1'b0;
        MDRIn      = 1'b0;
        IRIn       = 1'b0;
        YIn        = 1'b0;
        ZIn        = 1'b0;
        CONIn      = 1'b0;
        IncPC      = 1'b0;
        read       = 1'b0;
        add        = 1'b0;
        subtract   = 1'b0;
        Gra        = 1'b0;
        Grb        = 1'b0;
        Grc        = 1'b0;
        RIn        = 1'b0;
        Rout       = 1'b0;
        run        = 1'b1;
        illegal_op = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                state_d = S_T0;
            end
            S_T0: begin
                PCout   = 1'b1;
                MARIn   = 1'b1;
                IncPC   = 1'b1;
                ZIn     = 1'b1;
                state_d = S_T1;
            end
            S_T1: begin
                Zlowout = 1'b1;
                PCIn    = 1'b1;
                read    = 1'b1;
                MDRIn   = 1'b1;
                state_d = S_T2;
            end
            S_T2: begin
                MDRout  = 1'b1;
                IRIn    = 1'b1;
                state_d = S_T3;
            end
            S_T3: begin
                unique case (op_dec)
                    OP_ADD, OP_SUB, OP_ADDI: begin
                        Grb     = 1'b1;
                        Rout    = 1'b1;
                        YIn     = 1'b1;
                        state_d = S_T4;
                    end
                    OP_JR: begin
                        Gra     = 1'b1;
                        Rout    = 1'b1;
                        PCIn    = 1'b1;
                        state_d = eoi_state;
                    end
                    OP_BR: begin
                        Gra     = 1'b1;
                        Rout    = 1'b1;
                        CONIn   = 1'b1;
                        state_d = S_T4;
                    end
                    OP_HALT: begin
                        state_d = S_HALT;
                    end
                    OP_ILL: begin
                        illegal_op = 1'b1;
                        state_d    = eoi_state;
                    end
                    default: begin
                        state_d = eoi_state;
                    end
                endcase
            end
            S_T4: begin
                state_d = S_T5;
                unique case (op_q)
                    OP_ADD: begin
                        Grc  = 1'b1;
                        Rout = 1'b1;
                        add  = 1'b1;
                        ZIn  = 1'b1;
                    end
                    OP_SUB: begin
                        Grc      = 1'b1;
                        Rout     = 1'b1;
                        subtract = 1'b1;
                        ZIn      = 1'b1;
                    end
                    OP_ADDI: begin
                        Cout = 1'b1;
                        add  = 1'b1;
                        ZIn  = 1'b1;
                    end
                    OP_BR: begin
                        PCout = 1'b1;
                        YIn   = 1'b1;
                    end
                    default: begin
                        state_d = eoi_state;
                    end
                endcase
            end
            S_T5: begin
                state_d = eoi_state;
                unique case (op_q)
                    OP_ADD, OP_SUB, OP_ADDI: begin
                        Zlowout = 1'b1;
                        Gra     = 1'b1;
                        RIn     = 1'b1;
                    end
                    OP_BR: begin
                        Cout    = 1'b1;
                        add     = 1'b1;
                        ZIn     = 1'b1;
                        state_d = S_BR6;
                    end
                    default: begin
                        state_d = eoi_state;
                    end
                endcase
            end
            S_BR6: begin
                // Branch target is loaded only when the condition holds
                Zlowout = 1'b1;
                PCIn    = con_ff;
                state_d = eoi_state;
            end
            S_HALT: begin
                run     = 1'b0;
                state_d = S_HALT;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: hand-computed strobe sets per state.
// Strobes are sampled 1 time unit after each rising edge.
module tb_control_sequencer;

    logic        clk;
    logic        clr;
    logic [31:0] ir;
    logic        con_ff;
    logic        stop;
    logic        PCout, Zlowout, MDRout, Cout;
    logic        MARIn, PCIn, MDRIn, IRIn, YIn, ZIn, CONIn;
    logic        IncPC, read, add, subtract;
    logic        Gra, Grb, Grc, RIn, Rout;
    logic        run, illegal_op;

    int tests;
    int fails;

    localparam logic [19:0] M_PCOUT = 20'd1 << 19;
    localparam logic [19:0] M_ZLO   = 20'd1 << 18;
    localparam logic [19:0] M_MDRO  = 20'd1 << 17;
    localparam logic [19:0] M_COUT  = 20'd1 << 16;
    localparam logic [19:0] M_MARIN = 20'd1 << 15;
    localparam logic [19:0] M_PCIN  = 20'd1 << 14;
    localparam logic [19:0] M_MDRIN = 20'd1 << 13;
    localparam logic [19:0] M_IRIN  = 20'd1 << 12;
    localparam logic [19:0] M_YIN   = 20'd1 << 11;
    localparam logic [19:0] M_ZIN   = 20'd1 << 10;
    localparam logic [19:0] M_CONIN = 20'd1 << 9;
    localparam logic [19:0] M_INCPC = 20'd1 << 8;
    localparam logic [19:0] M_READ  = 20'd1 << 7;
    localparam logic [19:0] M_ADD   = 20'd1 << 6;
    localparam logic [19:0] M_SUB   = 20'd1 << 5;
    localparam logic [19:0] M_GRA   = 20'd1 << 4;
    localparam logic [19:0] M_GRB   = 20'd1 << 3;
    localparam logic [19:0] M_GRC   = 20'd1 << 2;
    localparam logic [19:0] M_RIN   = 20'd1 << 1;
    localparam logic [19:0] M_ROUT  = 20'd1 << 0;

    localparam logic [19:0] F0 = M_PCOUT | M_MARIN | M_INCPC | M_ZIN;
    localparam logic [19:0] F1 = M_ZLO | M_PCIN | M_READ | M_MDRIN;
    localparam logic [19:0] F2 = M_MDRO | M_IRIN;
    localparam logic [19:0] NONE = 20'd0;

    logic [19:0] strobes;
    assign strobes = {PCout, Zlowout, MDRout, Cout, MARIn, PCIn, MDRIn,
                      IRIn, YIn, ZIn, CONIn, IncPC, read, add, subtract,
                      Gra, Grb, Grc, RIn, Rout};

    control_sequencer dut (
        .clk        (clk),
        .clr        (clr),
        .ir         (ir),
        .con_ff     (con_ff),
        .stop       (stop),
        .PCout      (PCout),
        .Zlowout    (Zlowout),
        .MDRout     (MDRout),
        .Cout       (Cout),
        .MARIn      (MARIn),
        .PCIn       (PCIn),
        .MDRIn      (MDRIn),
        .IRIn       (IRIn),
        .YIn        (YIn),
        .ZIn        (ZIn),
        .CONIn      (CONIn),
        .IncPC      (IncPC),
        .read       (read),
        .add        (add),
        .subtract   (subtract),
        .Gra        (Gra),
        .Grb        (Grb),
        .Grc        (Grc),
        .RIn        (RIn),
        .Rout       (Rout),
        .run        (run),
        .illegal_op (illegal_op)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mk(input logic [4:0] op);
        return {op, 27'h1555555};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [19:0] es,
                         input logic er, input logic ei);
        logic [21:0] o;
        logic [21:0] e;
        o = {strobes, run, illegal_op};
        e = {es, er, ei};
        tests++;
        assert (o === e) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, o, e);
        end
    endtask

    initial begin
        tests  = 0;
        fails  = 0;
        clr    = 1'b0;
        stop   = 1'b0;
        con_ff = 1'b0;
        ir     = mk(5'b00011);

        repeat (2) tick();
        check("reset", NONE, 1'b1, 1'b0);
        clr = 1'b1;
        check("idle", NONE, 1'b1, 1'b0);

        tick(); check("add_t0", F0, 1'b1, 1'b0);
        tick(); check("add_t1", F1, 1'b1, 1'b0);
        tick(); check("add_t2", F2, 1'b1, 1'b0);
        tick(); check("add_t3", M_GRB | M_ROUT | M_YIN, 1'b1, 1'b0);
        tick(); check("add_t4", M_GRC | M_ROUT | M_ADD | M_ZIN, 1'b1, 1'b0);
        tick(); check("add_t5", M_ZLO | M_GRA | M_RIN, 1'b1, 1'b0);
        tick(); check("add_end", F0, 1'b1, 1'b0);

        ir = mk(5'b10100);
        tick(); check("jr_t1", F1, 1'b1, 1'b0);
        tick();
        tick(); check("jr_t3", M_GRA | M_ROUT | M_PCIN, 1'b1, 1'b0);
        tick(); check("jr_end", F0, 1'b1, 1'b0);

        ir = mk(5'b10011);
        tick(); tick();
        tick(); check("br1_t3", M_GRA | M_ROUT | M_CONIN, 1'b1, 1'b0);
        tick(); check("br1_t4", M_PCOUT | M_YIN, 1'b1, 1'b0);
        tick(); check("br1_t5", M_COUT | M_ADD | M_ZIN, 1'b1, 1'b0);
        con_ff = 1'b1;
        tick(); check("br1_br6", M_ZLO | M_PCIN, 1'b1, 1'b0);
        tick(); check("br1_end", F0, 1'b1, 1'b0);

        con_ff = 1'b0;
        tick(); tick(); tick(); tick(); tick();
        tick(); check("br0_br6", M_ZLO, 1'b1, 1'b0);
        tick(); check("br0_end", F0, 1'b1, 1'b0);

        ir = mk(5'b11111);
        tick(); tick();
        tick(); check("ill_t3", NONE, 1'b1, 1'b1);
        tick(); check("ill_end", F0, 1'b1, 1'b0);

        ir = mk(5'b11010);
        tick(); tick();
        tick(); check("nop_t3", NONE, 1'b1, 1'b0);
        tick(); check("nop_end", F0, 1'b1, 1'b0);

        ir = mk(5'b00100);
        tick(); tick();
        tick(); check("sub_t3", M_GRB | M_ROUT | M_YIN, 1'b1, 1'b0);
        tick(); check("sub_t4", M_GRC | M_ROUT | M_SUB | M_ZIN, 1'b1, 1'b0);
        #2 clr = 1'b0;
        #1 check("async_clr", NONE, 1'b1, 1'b0);
        #1 clr = 1'b1;
        tick(); check("rst_t0", F0, 1'b1, 1'b0);

        ir = mk(5'b01100);
        tick(); tick();
        tick(); check("addi_t3", M_GRB | M_ROUT | M_YIN, 1'b1, 1'b0);
        tick(); check("addi_t4", M_COUT | M_ADD | M_ZIN, 1'b1, 1'b0);
        tick(); check("addi_t5", M_ZLO | M_GRA | M_RIN, 1'b1, 1'b0);
        tick(); check("addi_end", F0, 1'b1, 1'b0);

        ir = mk(5'b00011);
        tick();
        stop = 1'b1;
        tick(); check("stop_t2", F2, 1'b1, 1'b0);
        tick(); check("stop_t3", M_GRB | M_ROUT | M_YIN, 1'b1, 1'b0);
        tick(); check("stop_t4", M_GRC | M_ROUT | M_ADD | M_ZIN, 1'b1, 1'b0);
        tick(); check("stop_t5", M_ZLO | M_GRA | M_RIN, 1'b1, 1'b0);
        tick(); check("stop_halt", NONE, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            tick(); check("stop_hold", NONE, 1'b0, 1'b0);
        end
        stop = 1'b0;
        clr  = 1'b0;
        #1 check("stop_clr", NONE, 1'b1, 1'b0);

        tick();
        clr = 1'b1;
        ir  = mk(5'b11011);
        tick(); check("halt_t0", F0, 1'b1, 1'b0);
        tick(); tick();
        tick(); check("halt_t3", NONE, 1'b1, 1'b0);
        tick(); check("halt_enter", NONE, 1'b0, 1'b0);
        for (int i = 0; i < 12; i++) begin
            tick(); check("halt_hold", NONE, 1'b0, 1'b0);
        end
        clr = 1'b0;
        #1 check("halt_exit", NONE, 1'b1, 1'b0);
        clr = 1'b1;
        tick(); check("exit_t0", F0, 1'b1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
